// File: rtl/app_cmd_pkg.sv
// Shared opcodes, FSM state encoding and the LFSR byte-step function for app_cmd_engine.
package app_cmd_pkg;

  localparam logic [7:0] OP_WAIT      = 8'h01;
  localparam logic [7:0] OP_ADDR      = 8'h02;
  localparam logic [7:0] OP_MEM_READ  = 8'h03;
  localparam logic [7:0] OP_MEM_WRITE = 8'h04;
  localparam logic [7:0] OP_LFSR_SEED = 8'h05;
  localparam logic [7:0] OP_LFSR_IN   = 8'h06;
  localparam logic [7:0] OP_LFSR_OUT  = 8'h07;

  typedef enum logic [2:0] {
    S_IDLE, S_ARGS, S_MEM_RD, S_MEM_WR, S_LFSR_IN, S_LFSR_OUT, S_STATUS, S_GAP
  } state_e;

  // States in which the engine takes bytes from the host.
  function automatic logic accepts_out(input state_e s);
    return s inside {S_IDLE, S_ARGS, S_MEM_WR, S_LFSR_OUT};
  endfunction

  // Eight Galois steps; callers zero-extend state and mask (width up to 64).
  function automatic logic [63:0] lfsr_step8(input logic [63:0] s, input logic [63:0] poly);
    logic [63:0] v;
    v = s;
    for (int i = 0; i < 8; i++) begin
      v = (v >> 1) ^ (v[0] ? poly : 64'd0);
    end
    return v;
  endfunction

endpackage

// File: rtl/app_cmd_engine_lfsr.sv
// One LFSR channel: seed load, byte-wide step on enable, low byte as output.
module app_lfsr
  import app_cmd_pkg::*;
#(
  parameter int             W    = 24,
  parameter logic [W-1:0]   POLY = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         seed_ld_i,
  input  logic [W-1:0] seed_i,
  input  logic         step_i,
  output logic [7:0]   byte_o
);

  logic [W-1:0] state_q;
  logic [63:0]  step_full;

  assign step_full = lfsr_step8(64'(state_q), 64'(POLY));
  assign byte_o    = state_q[7:0];

  // Upper bits of the wide step result are always zero for W < 64.
  if (W < 64) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^step_full[63:W];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= '0;
    end else if (seed_ld_i) begin
      state_q <= seed_i;
    end else if (step_i) begin
      state_q <= step_full[W-1:0];
    end
  end

endmodule

// File: rtl/app_cmd_engine.sv
// Byte-stream command engine: argument shifter, memory port, LFSR generators/checkers.
module app_cmd_engine
  import app_cmd_pkg::*;
#(
  parameter int                 ADDR_BYTES = 3,
  parameter int                 LEN_BYTES  = 3,
  parameter int                 LFSR_CH    = 2,
  parameter int                 LFSR_W     = 24,
  parameter logic [LFSR_W-1:0]  LFSR_POLY  = 24'hE10000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [7:0]              out_data_i,
  input  logic                    out_valid_i,
  output logic                    out_ready_o,
  output logic [7:0]              in_data_o,
  output logic                    in_valid_o,
  input  logic                    in_ready_i,
  output logic [8*ADDR_BYTES-1:0] mem_addr_o,
  output logic                    mem_rd_o,
  input  logic [7:0]              mem_rdata_i,
  output logic                    mem_wr_o,
  output logic [7:0]              mem_wdata_o,
  output logic                    err_o,
  output logic                    busy_o
);

  localparam int AW    = 8 * ADDR_BYTES;
  localparam int LW    = 8 * LEN_BYTES;
  localparam int SB    = LFSR_W / 8;
  localparam int MAXB0 = (ADDR_BYTES > LEN_BYTES) ? ADDR_BYTES : LEN_BYTES;
  localparam int MAXB  = (MAXB0 > SB) ? MAXB0 : SB;

  state_e              state_q, ret_q;
  logic [7:0]          op_q, arg_idx_q, arg_left_q, wait_q, gap_q, ch_q, cnt_q;
  logic [7:0]          in_data_q, mem_wdata_q;
  logic [8*MAXB-1:0]   arg_q, arg_m;
  logic [AW-1:0]       addr_q;
  logic [LW-1:0]       len_q;
  logic                out_ready_q, in_valid_q, mem_rd_q, rd_pend_q, mem_wr_q, err_q;

  logic                out_hs, in_hs, has_ch, arg_last, ch_ok, known, mis;
  logic                seed_ld_any, step_any;
  logic [7:0]          pos, nargs, gen_byte, cnt_next;
  logic [7:0]          lfsr_byte [LFSR_CH];

  // Ready is forced low while reset is held so no byte is taken during reset.
  assign out_ready_o = out_ready_q & ~rst_i;
  assign in_data_o   = in_data_q;
  assign in_valid_o  = in_valid_q;
  assign mem_addr_o  = addr_q;
  assign mem_rd_o    = mem_rd_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_IDLE);

  assign out_hs   = out_valid_i & out_ready_o;
  assign in_hs    = in_valid_q & in_ready_i;
  assign has_ch   = op_q inside {OP_LFSR_SEED, OP_LFSR_IN, OP_LFSR_OUT};
  assign arg_last = (arg_left_q == 8'd1);
  assign ch_ok    = (ch_q < 8'(LFSR_CH));
  assign pos      = arg_idx_q - {7'd0, has_ch};

  assign seed_ld_any = (state_q == S_ARGS) && out_hs && arg_last && (op_q == OP_LFSR_SEED) && ch_ok;
  assign step_any    = ((state_q == S_LFSR_IN) && in_hs) || ((state_q == S_LFSR_OUT) && out_hs);

  always_comb begin
    arg_m = arg_q;
    for (int b = 0; b < MAXB; b++) begin
      if (pos == 8'(b)) arg_m[8*b +: 8] = out_data_i;
    end
    gen_byte = 8'd0;
    for (int i = 0; i < LFSR_CH; i++) begin
      if (ch_q == 8'(i)) gen_byte = lfsr_byte[i];
    end
    mis      = ch_ok && (out_data_i != gen_byte);
    cnt_next = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + {7'd0, mis};
  end

  always_comb begin
    known = 1'b1;
    nargs = 8'd0;
    case (out_data_i)
      OP_WAIT:                  nargs = 8'd1;
      OP_ADDR:                  nargs = 8'(ADDR_BYTES);
      OP_MEM_READ, OP_MEM_WRITE: nargs = 8'(LEN_BYTES);
      OP_LFSR_SEED:             nargs = 8'(1 + SB);
      OP_LFSR_IN, OP_LFSR_OUT:  nargs = 8'(1 + LEN_BYTES);
      default:                  known = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < LFSR_CH; gi++) begin : g_ch
    app_lfsr #(.W(LFSR_W), .POLY(LFSR_POLY)) u_lfsr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .seed_ld_i (seed_ld_any && (ch_q == 8'(gi))),
      .seed_i    (arg_m[LFSR_W-1:0]),
      .step_i    (step_any && (ch_q == 8'(gi))),
      .byte_o    (lfsr_byte[gi])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;  ret_q <= S_IDLE;
      op_q <= '0;  arg_idx_q <= '0;  arg_left_q <= '0;  arg_q <= '0;
      wait_q <= '0;  gap_q <= '0;  ch_q <= '0;  cnt_q <= '0;
      in_data_q <= '0;  mem_wdata_q <= '0;  addr_q <= '0;  len_q <= '0;
      out_ready_q <= 1'b1;  in_valid_q <= 1'b0;  mem_rd_q <= 1'b0;
      rd_pend_q <= 1'b0;  mem_wr_q <= 1'b0;  err_q <= 1'b0;
    end else begin
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      // Address advances the cycle after each write pulse so the pulse shows its own address.
      if (mem_wr_q) addr_q <= addr_q + AW'(1);
      case (state_q)
        S_IDLE: begin
          if (out_hs) begin
            if (known) begin
              op_q <= out_data_i;  arg_left_q <= nargs;  arg_idx_q <= '0;  arg_q <= '0;
              state_q <= S_ARGS;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ARGS: begin
          if (out_hs) begin
            arg_q <= arg_m;
            arg_idx_q <= arg_idx_q + 8'd1;
            arg_left_q <= arg_left_q - 8'd1;
            if (has_ch && arg_idx_q == 8'd0) ch_q <= out_data_i;
            if (arg_last) begin
              state_q <= S_IDLE;
              out_ready_q <= accepts_out(S_IDLE);
              case (op_q)
                OP_WAIT: wait_q <= arg_m[7:0];
                OP_ADDR: addr_q <= arg_m[AW-1:0];
                OP_MEM_READ: begin
                  len_q <= arg_m[LW-1:0];  state_q <= S_MEM_RD;  mem_rd_q <= 1'b1;
                  out_ready_q <= accepts_out(S_MEM_RD);
                end
                OP_MEM_WRITE: begin
                  len_q <= arg_m[LW-1:0];  state_q <= S_MEM_WR;
                  out_ready_q <= accepts_out(S_MEM_WR);
                end
                OP_LFSR_SEED: if (!ch_ok) err_q <= 1'b1;
                OP_LFSR_IN: begin
                  len_q <= arg_m[LW-1:0];  state_q <= S_LFSR_IN;  in_valid_q <= 1'b0;
                  out_ready_q <= accepts_out(S_LFSR_IN);
                  if (!ch_ok) err_q <= 1'b1;
                end
                OP_LFSR_OUT: begin
                  len_q <= arg_m[LW-1:0];  state_q <= S_LFSR_OUT;  cnt_q <= '0;
                  out_ready_q <= accepts_out(S_LFSR_OUT);
                  if (!ch_ok) err_q <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        S_MEM_RD: begin
          if (mem_rd_q) begin
            rd_pend_q <= 1'b1;
          end else if (rd_pend_q) begin
            rd_pend_q <= 1'b0;  in_data_q <= mem_rdata_i;  in_valid_q <= 1'b1;
          end else if (in_hs) begin
            in_valid_q <= 1'b0;
            addr_q <= addr_q + AW'(1);
            if (len_q == '0) begin
              state_q <= S_IDLE;  out_ready_q <= accepts_out(S_IDLE);
            end else begin
              len_q <= len_q - LW'(1);
              if (wait_q != 8'd0) begin
                state_q <= S_GAP;  gap_q <= wait_q;  ret_q <= S_MEM_RD;
              end else begin
                mem_rd_q <= 1'b1;
              end
            end
          end
        end
        S_MEM_WR: begin
          if (out_hs) begin
            mem_wr_q <= 1'b1;  mem_wdata_q <= out_data_i;
            if (len_q == '0) state_q <= S_IDLE;
            else             len_q <= len_q - LW'(1);
          end
        end
        S_LFSR_IN: begin
          if (!in_valid_q) begin
            in_data_q <= gen_byte;  in_valid_q <= 1'b1;
          end else if (in_hs) begin
            in_valid_q <= 1'b0;
            if (len_q == '0) begin
              state_q <= S_IDLE;  out_ready_q <= accepts_out(S_IDLE);
            end else begin
              len_q <= len_q - LW'(1);
              if (wait_q != 8'd0) begin
                state_q <= S_GAP;  gap_q <= wait_q;  ret_q <= S_LFSR_IN;
              end
            end
          end
        end
        S_LFSR_OUT: begin
          if (out_hs) begin
            cnt_q <= cnt_next;
            if (len_q == '0) begin
              state_q <= S_STATUS;  out_ready_q <= accepts_out(S_STATUS);
              in_data_q <= cnt_next;  in_valid_q <= 1'b1;
            end else begin
              len_q <= len_q - LW'(1);
            end
          end
        end
        S_STATUS: begin
          if (in_hs) begin
            in_valid_q <= 1'b0;  state_q <= S_IDLE;  out_ready_q <= accepts_out(S_IDLE);
          end
        end
        S_GAP: begin
          if (gap_q <= 8'd1) begin
            state_q <= ret_q;
            if (ret_q == S_MEM_RD) mem_rd_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;  out_ready_q <= accepts_out(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_app_cmd_engine.sv
// Self-checking bench for app_cmd_engine: table rows, directed sequences, random LFSR traffic.
module tb_app_cmd_engine;

  localparam int TMO = 2000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  out_data_i = '0;
  logic        out_valid_i = 1'b0;
  logic        out_ready_o;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i = 1'b0;
  logic [23:0] mem_addr_o;
  logic        mem_rd_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_wr_o;
  logic [7:0]  mem_wdata_o;
  logic        err_o;
  logic        busy_o;

  always #5 clk = ~clk;

  app_cmd_engine dut (
    .clk_i(clk), .rst_i(rst_i),
    .out_data_i(out_data_i), .out_valid_i(out_valid_i), .out_ready_o(out_ready_o),
    .in_data_o(in_data_o), .in_valid_o(in_valid_o), .in_ready_i(in_ready_i),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_rdata_i(mem_rdata_i),
    .mem_wr_o(mem_wr_o), .mem_wdata_o(mem_wdata_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  // Memory model with one-cycle registered read.
  logic [7:0]  mem [0:4095];
  always @(posedge clk) begin
    if (mem_wr_o) mem[mem_addr_o[11:0]] <= mem_wdata_o;
    if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o[11:0]];
  end

  logic [23:0] rd_log [$];
  logic [23:0] wr_log [$];
  logic [7:0]  wd_log [$];
  always @(negedge clk) begin
    if (mem_rd_o) rd_log.push_back(mem_addr_o);
    if (mem_wr_o) begin
      wr_log.push_back(mem_addr_o);
      wd_log.push_back(mem_wdata_o);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Galois rule: shift right, xor in the mask whenever a one falls out, eight times per byte.
  function automatic logic [23:0] ref_step(input logic [23:0] s);
    logic [23:0] v;
    v = s;
    for (int k = 0; k < 8; k++) begin
      if (v[0]) v = (v >> 1) ^ 24'hE10000;
      else      v = v >> 1;
    end
    return v;
  endfunction

  task automatic do_reset();
    out_valid_i = 1'b0;
    in_ready_i  = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    out_data_i  = b;
    out_valid_i = 1'b1;
    while (!out_ready_o && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!out_ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: out_ready_o=0 required 1 for byte %0h", b);
      out_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      out_valid_i = 1'b0;
    end
  endtask

  task automatic recv(output logic [7:0] b);
    int n;
    n = 0;
    in_ready_i = 1'b1;
    while (!in_valid_o && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!in_valid_o) begin
      checks++;
      errors++;
      $display("FAIL recv_timeout: in_valid_o=0 required 1");
      b = 8'h00;
      in_ready_i = 1'b0;
    end else begin
      b = in_data_o;
      @(posedge clk);
      @(negedge clk);
      in_ready_i = 1'b0;
    end
  endtask

  task automatic send24(input logic [23:0] v);
    send(v[7:0]);
    send(v[15:8]);
    send(v[23:16]);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy_o, 1'b0);
  endtask

  typedef struct {
    logic [39:0] bytes;
    int          n;
    logic        exp_err;
  } row_t;

  row_t rows [8];

  initial begin
    logic [7:0]  b, gen, st;
    logic [23:0] m;
    logic [39:0] v;
    logic [23:0] mdl [0:2];
    logic        merr;
    int          base, got, idle, cnt, ch, kind, n;
    logic        pv, ph;
    logic [7:0]  pd;

    rows[0] = '{40'h00_00_00_00_01, 2, 1'b0};
    rows[1] = '{40'h00_00_00_00_5A, 1, 1'b1};
    rows[2] = '{40'h00_00_00_00_00, 1, 1'b1};
    rows[3] = '{40'h00_00_00_00_08, 1, 1'b1};
    rows[4] = '{40'h33_22_11_07_05, 5, 1'b1};
    rows[5] = '{40'h33_22_11_01_05, 5, 1'b0};
    rows[6] = '{40'h00_00_00_10_02, 4, 1'b0};
    rows[7] = '{40'h00_00_00_00_FF, 1, 1'b1};

    // Reset state, sampled while reset is still held.
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_ready", out_ready_o, 1'b0);
    chk("rst_in_valid", in_valid_o, 1'b0);
    chk("rst_mem_rd", mem_rd_o, 1'b0);
    chk("rst_mem_wr", mem_wr_o, 1'b0);
    chk("rst_mem_addr", mem_addr_o, 24'h0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_out_ready", out_ready_o, 1'b1);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      v = rows[i].bytes;
      for (int j = 0; j < rows[i].n; j++) send(v[j*8 +: 8]);
      @(negedge clk);
      chk($sformatf("row%0d_err", i), err_o, rows[i].exp_err);
      chk($sformatf("row%0d_busy", i), busy_o, 1'b0);
    end

    // Memory write then read back.
    do_reset();
    base = wr_log.size();
    send(8'h02); send24(24'h000010);
    send(8'h04); send24(24'h000003);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    @(negedge clk);
    @(negedge clk);
    chk("wr_count", wr_log.size() - base, 4);
    if (wr_log.size() - base >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wr_addr%0d", i), wr_log[base+i], 24'h10 + i);
        chk($sformatf("wr_data%0d", i), wd_log[base+i], 8'hAA + 8'(17*i));
      end
    end
    send(8'h02); send24(24'h000010);
    send(8'h03); send24(24'h000003);
    for (int i = 0; i < 4; i++) begin
      recv(b);
      chk($sformatf("rd_data%0d", i), b, 8'hAA + 8'(17*i));
    end
    wait_idle("rd_done_idle");

    // Address wrap on read.
    base = rd_log.size();
    send(8'h02); send24(24'hFFFFFE);
    send(8'h03); send24(24'h000003);
    for (int i = 0; i < 4; i++) recv(b);
    wait_idle("wrap_idle");
    chk("wrap_count", rd_log.size() - base, 4);
    if (rd_log.size() - base >= 4) begin
      chk("wrap_a0", rd_log[base+0], 24'hFFFFFE);
      chk("wrap_a1", rd_log[base+1], 24'hFFFFFF);
      chk("wrap_a2", rd_log[base+2], 24'h000000);
      chk("wrap_a3", rd_log[base+3], 24'h000001);
    end

    // LFSR generator.
    send(8'h05); send(8'h00); send24(24'h123456);
    send(8'h05); send(8'h01); send24(24'h333881);
    send(8'h06); send(8'h01); send24(24'd9);
    m = 24'h333881;
    for (int i = 0; i < 10; i++) begin
      recv(b);
      chk($sformatf("lfsr_in%0d", i), b, m[7:0]);
      m = ref_step(m);
    end
    send(8'h06); send(8'h00); send24(24'd0);
    recv(b);
    chk("ch0_unchanged", b, 8'h56);
    wait_idle("lfsr_in_idle");

    // LFSR checker: one flipped byte, then saturation.
    send(8'h05); send(8'h01); send24(24'h333881);
    send(8'h07); send(8'h01); send24(24'd9);
    m = 24'h333881;
    for (int i = 0; i < 10; i++) begin
      send(m[7:0] ^ ((i == 4) ? 8'h01 : 8'h00));
      m = ref_step(m);
    end
    recv(st);
    chk("status_one", st, 8'h01);
    send(8'h05); send(8'h01); send24(24'h333881);
    send(8'h07); send(8'h01); send24(24'd299);
    m = 24'h333881;
    for (int i = 0; i < 300; i++) begin
      send(~m[7:0]);
      m = ref_step(m);
    end
    recv(st);
    chk("status_sat", st, 8'hFF);
    chk("no_err_yet", err_o, 1'b0);

    // Unknown opcode, then a normal command.
    send(8'h5A);
    @(negedge clk);
    chk("bad_op_err", err_o, 1'b1);
    chk("bad_op_busy", busy_o, 1'b0);
    send(8'h02); send24(24'h000010);
    send(8'h03); send24(24'h000000);
    recv(b);
    chk("after_bad_op", b, 8'hAA);
    wait_idle("after_bad_idle");

    // WAIT 5, read two bytes while in_ready toggles.
    send(8'h01); send(8'h05);
    send(8'h02); send24(24'h000010);
    send(8'h03); send24(24'h000001);
    got = 0; idle = 0; pv = 1'b0; ph = 1'b0; pd = 8'h00;
    for (int k = 0; k < 400 && got < 2; k++) begin
      @(negedge clk);
      if (pv && !ph) begin
        chk("stall_valid", in_valid_o, 1'b1);
        chk("stall_data", in_data_o, pd);
      end
      if (got == 1 && !in_valid_o) idle++;
      in_ready_i = k[0];
      pv = in_valid_o;
      pd = in_data_o;
      ph = in_valid_o && in_ready_i;
      if (ph) begin
        got++;
        chk($sformatf("gap_data%0d", got), pd, (got == 1) ? 8'hAA : 8'hBB);
      end
    end
    @(negedge clk);
    in_ready_i = 1'b0;
    chk("gap_bytes", got, 2);
    chk("gap_ge5", (idle >= 5), 1'b1);
    wait_idle("gap_idle");

    // Reset in the middle of a read.
    send(8'h01); send(8'h00);
    send(8'h02); send24(24'h000010);
    send(8'h03); send24(24'h000003);
    n = 0;
    while (!in_valid_o && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("midrd_valid", in_valid_o, 1'b1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrd_in_valid", in_valid_o, 1'b0);
    chk("midrd_busy", busy_o, 1'b0);
    chk("midrd_addr", mem_addr_o, 24'h0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrd_ready", out_ready_o, 1'b1);

    // Random LFSR traffic against the channel model.
    do_reset();
    mdl[0] = '0; mdl[1] = '0; mdl[2] = '0;
    merr = 1'b0;
    for (int it = 0; it < 24; it++) begin
      ch   = $urandom_range(0, 2);
      kind = (it < 2) ? 0 : $urandom_range(0, 2);
      if (kind == 0) begin
        m = 24'($urandom);
        send(8'h05); send(8'(ch)); send24(m);
        if (ch < 2) mdl[ch] = m;
        else        merr = 1'b1;
      end else if (kind == 1) begin
        n = $urandom_range(1, 12);
        send(8'h06); send(8'(ch)); send24(24'(n - 1));
        for (int i = 0; i < n; i++) begin
          recv(b);
          chk($sformatf("rnd%0d_in%0d", it, i), b, (ch < 2) ? mdl[ch][7:0] : 8'h00);
          if (ch < 2) mdl[ch] = ref_step(mdl[ch]);
        end
        if (ch >= 2) merr = 1'b1;
      end else begin
        n = $urandom_range(1, 12);
        cnt = 0;
        send(8'h07); send(8'(ch)); send24(24'(n - 1));
        for (int i = 0; i < n; i++) begin
          gen = (ch < 2) ? mdl[ch][7:0] : 8'h00;
          b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : gen;
          if (ch < 2 && b != gen && cnt < 255) cnt++;
          send(b);
          if (ch < 2) mdl[ch] = ref_step(mdl[ch]);
        end
        recv(st);
        chk($sformatf("rnd%0d_status", it), st, 8'(cnt));
        if (ch >= 2) merr = 1'b1;
      end
      wait_idle($sformatf("rnd%0d_idle", it));
      chk($sformatf("rnd%0d_err", it), err_o, merr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/app_cmd_engine.md
Name: app_cmd_engine

Overview:
- Parametrised byte-stream command processor between the usb_cdc bulk OUT/IN application streams and on-chip memory plus N LFSR test generators/checkers.
- Successor to the single-channel demo app.
- Generalised in:
  - address and length field widths
  - LFSR channel count and polynomial
- New behaviour:
  - memory write
  - an OUT-check command that returns a mismatch count
  - sticky error on unknown opcodes

Parameters:
- ADDR_BYTES, 3, bytes in address argument; address width AW = 8*ADDR_BYTES
- LEN_BYTES, 3, bytes in length argument (length-1 encoded); LW = 8*LEN_BYTES
- LFSR_CH, 2, number of independent LFSR channels (1..16)
- LFSR_W, 24, LFSR state width (multiple of 8, >=16)
- LFSR_POLY, 24'hE10000, Galois feedback mask, LFSR_W bits

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- out_data_i  in  8  byte from host (usb_cdc out stream)
- out_valid_i  in  1  out byte valid
- out_ready_o  out  1  engine accepts out byte
- in_data_o  out  8  byte to host
- in_valid_o  out  1  in byte valid
- in_ready_i  in  1  usb_cdc accepts in byte
- mem_addr_o  out  AW  memory address
- mem_rd_o  out  1  read strobe; data on mem_rdata_i next cycle
- mem_rdata_i  in  8  read data
- mem_wr_o  out  1  write strobe
- mem_wdata_o  out  8  write data
- err_o  out  1  sticky unknown-opcode flag
- busy_o  out  1  high when not in IDLE

Behaviour:
- Handshakes: a transfer occurs when valid&ready are both high at the clock edge. in_valid_o/in_data_o hold stable until accepted.
- Reset: state=IDLE; out_ready_o=0 the cycle reset is high, then 1 in IDLE; in_valid_o=0; mem_rd_o=mem_wr_o=0; mem_addr_o=0; err_o=0; wait_q=0; all LFSR states=0; length/arg counters=0.
- Reset mid-operation aborts any command immediately. No partial output is completed.
- Multi-byte arguments are little-endian and shifted in one per accepted out byte.
- States: IDLE, ARGS, MEM_RD, MEM_WR, LFSR_IN, LFSR_OUT, STATUS, GAP.
- IDLE: accepts opcode byte.
  - Known opcode -> ARGS with arg count set per opcode.
  - Unknown opcode -> err_o=1, stay IDLE.
- Opcodes:
  - 0x01 WAIT: 1 arg -> wait_q.
  - 0x02 ADDR: ADDR_BYTES args -> addr_q.
  - 0x03 MEM_READ: LEN_BYTES args -> len_q; then MEM_RD.
  - 0x04 MEM_WRITE: LEN_BYTES args; then MEM_WR.
  - 0x05 LFSR_SEED: 1 channel byte, then LFSR_W/8 seed bytes. Channel >= LFSR_CH sets err_o and seed is discarded.
  - 0x06 LFSR_IN: 1 channel byte + LEN_BYTES; then LFSR_IN.
  - 0x07 LFSR_OUT: 1 channel byte + LEN_BYTES; then LFSR_OUT.
- Settings commands (WAIT, ADDR, SEED) return to IDLE and are visible internally the cycle after the last arg byte.
- MEM_RD:
  - out_ready_o=0.
  - Pulses mem_rd_o with mem_addr_o=addr_q.
  - Next cycle captures mem_rdata_i into in_data_o and sets in_valid_o.
  - On accept: addr_q+1 (wraps modulo 2^AW), len-1, GAP if wait_q!=0, else next read.
  - len+1 bytes total, then IDLE.
- MEM_WR:
  - out_ready_o=1.
  - Each accepted byte gives a one-cycle mem_wr_o with the byte and addr_q; then addr_q+1 (wrapping).
  - len+1 bytes total.
- LFSR stepping: output byte = state[7:0]; then state <= (state>>1) ^ (state[0] ? LFSR_POLY : 0), repeated 8 times per byte, all in one cycle. All-zero state stays zero (no lock-up fix).
- LFSR_IN: emits len+1 generated bytes from the selected channel; the LFSR steps only on in handshake.
- LFSR_OUT:
  - Accepts len+1 bytes and compares each with the generated byte; the channel steps per accepted byte.
  - Mismatch counter is 8-bit, saturating at 255.
  - Then STATUS emits one byte = count, then IDLE.
- GAP: counts wait_q idle cycles between IN-side bytes, then resumes.
- Channel >= LFSR_CH on IN/OUT: err_o set. IN returns zeros; OUT returns count 0 after consuming the bytes.
- addr_q persists across commands. MEM_READ following MEM_WRITE continues from the post-write address.
- busy_o is combinational from state.

Decomposition:
- app_cmd_pkg: opcode localparams, state encoding, and the LFSR byte-step function (8 Galois steps).
- Sub-module app_lfsr: one channel instance holding the state, with seed load, step enable and byte output, instantiated LFSR_CH times via generate.
- The engine holds the FSM, argument shifter, counters and memory port.

Test Plan:
- Reset, then ADDR 0x000010 and MEM_WRITE len-1=3 with AA BB CC DD -> four mem_wr_o pulses at 0x10..0x13. ADDR 0x10 and MEM_READ 3 -> IN AA BB CC DD.
- ADDR 0xFFFFFE, MEM_READ 3 -> mem_addr_o sequence FFFFFE, FFFFFF, 000000, 000001 (wrap).
- LFSR_SEED ch1 = 0x333881, LFSR_IN ch1 len 10 -> first byte 0x81, remaining bytes match the package reference step. ch0 is unchanged.
- Reseed ch1 = 0x333881, LFSR_OUT ch1 with the same 10 bytes but byte 4 flipped -> status byte 0x01. With 300 bytes all inverted -> 0xFF (saturation).
- Opcode 0x5A -> err_o=1, engine stays IDLE, and the next valid command executes normally.
- WAIT 5 then MEM_READ 1 with in_ready_i toggling -> >=5 idle cycles between bytes and data held stable while stalled. Reset asserted mid-read -> in_valid_o=0 next cycle, state IDLE.
